// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter unit: FSM states,
// command codes, readout selects and overflow bit positions.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_START = 2'd1,
    CMD_STOP  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  localparam logic [2:0] SEL_CYCLES  = 3'd0;
  localparam logic [2:0] SEL_RETIRED = 3'd1;
  localparam logic [2:0] SEL_CTRL    = 3'd2;
  localparam logic [2:0] SEL_MISPRED = 3'd3;
  localparam logic [2:0] SEL_BUBBLES = 3'd4;
  localparam logic [2:0] SEL_OVF     = 3'd5;
  localparam logic [2:0] SEL_PC      = 3'd6;
  localparam logic [2:0] SEL_MISPC   = 3'd7;

  // Counter slots double as overflow bit positions in the SEL_OVF word.
  localparam int NUM_CNT     = 5;
  localparam int OVF_CYCLES  = 0;
  localparam int OVF_RETIRED = 1;
  localparam int OVF_CTRL    = 2;
  localparam int OVF_MISPRED = 3;
  localparam int OVF_BUBBLES = 4;

endpackage

// File: rtl/perf_counter_unit_if.sv
// Bundle of commit-stream, command and readout signals between the core
// (or a testbench) and perf_counter_unit.
interface perf_counter_unit_if;
  logic        i_insn_vld;
  logic        i_ctrl;
  logic        i_mispred;
  logic [31:0] i_pc;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic        o_cmd_ready;
  logic [2:0]  i_rd_sel;
  logic [2:0]  i_trace_idx;
  logic [31:0] o_rd_data;
  logic [1:0]  o_state;
  logic        o_ovf;

  modport master (
    output i_insn_vld, i_ctrl, i_mispred, i_pc, i_cmd_valid, i_cmd,
           i_rd_sel, i_trace_idx,
    input  o_cmd_ready, o_rd_data, o_state, o_ovf
  );

  modport slave (
    input  i_insn_vld, i_ctrl, i_mispred, i_pc, i_cmd_valid, i_cmd,
           i_rd_sel, i_trace_idx,
    output o_cmd_ready, o_rd_data, o_state, o_ovf
  );
endinterface

// File: rtl/perf_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clear has priority
// over increment.
module perf_sat_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  output logic [COUNT_W-1:0] count,
  output logic               ovf
);

  localparam logic [COUNT_W-1:0] MAX = {COUNT_W{1'b1}};

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == MAX) ovf <= 1'b1;
      else              count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Commit-stream performance counters under a start/stop/clear FSM with a
// registered readout. Define PERF_MISPRED_TRACE_EN to add a mispredict PC trace.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int COUNT_W     = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  perf_counter_unit_if.slave  bus
);

  localparam logic [2:0] TRACE_MASK = 3'(TRACE_DEPTH - 1);

  state_e state, state_next;
  cmd_e   cmd;
  logic   cmd_accept;
  logic   running, clearing;
  logic   commit, mispred_commit;

  assign cmd             = cmd_e'(bus.i_cmd);
  assign bus.o_cmd_ready = (state != ST_CLEAR);
  assign cmd_accept      = bus.i_cmd_valid & bus.o_cmd_ready;
  assign bus.o_state     = state;

  assign running         = (state == ST_RUN);
  assign clearing        = (state == ST_CLEAR);
  assign commit          = running & bus.i_insn_vld;
  assign mispred_commit  = commit & bus.i_mispred;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (state == ST_CLEAR) begin
      state_next = ST_IDLE;
    end else if (cmd_accept) begin
      case (cmd)
        CMD_START: if (state != ST_RUN) state_next = ST_RUN;
        CMD_STOP:  if (state == ST_RUN) state_next = ST_FROZEN;
        CMD_CLEAR: state_next = ST_CLEAR;
        default:   state_next = state;
      endcase
    end
  end

  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] ovf;
  logic [COUNT_W-1:0] cnt [NUM_CNT];

  always_comb begin
    inc              = '0;
    inc[OVF_CYCLES]  = running;
    inc[OVF_RETIRED] = commit;
    inc[OVF_CTRL]    = commit & bus.i_ctrl;
    inc[OVF_MISPRED] = mispred_commit;
    inc[OVF_BUBBLES] = running & ~bus.i_insn_vld;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
      .clk   (i_clk),
      .rst   (i_reset),
      .clear (clearing),
      .inc   (inc[g]),
      .count (cnt[g]),
      .ovf   (ovf[g])
    );
  end

  assign bus.o_ovf = |ovf;

  logic [31:0] last_pc, last_mispc, mispc_read;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_pc    <= '0;
      last_mispc <= '0;
    end else if (clearing) begin
      last_pc    <= '0;
      last_mispc <= '0;
    end else begin
      if (commit)         last_pc    <= bus.i_pc;
      if (mispred_commit) last_mispc <= bus.i_pc;
    end
  end

`ifdef PERF_MISPRED_TRACE_EN
  logic [31:0] trace_mem [TRACE_DEPTH];
  logic [2:0]  trace_ptr;
  logic [2:0]  trace_rd_ptr;

  // NOTE: the buffer is reset, not left as plain RAM, because unwritten entries must read 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      trace_ptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
    end else if (clearing) begin
      trace_ptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
    end else if (mispred_commit) begin
      trace_mem[trace_ptr & TRACE_MASK] <= bus.i_pc;
      trace_ptr                         <= trace_ptr + 3'd1;
    end
  end

  // The 3-bit pointer wraps mod 8; masking folds it to any power-of-two depth.
  assign trace_rd_ptr = (trace_ptr - 3'd1 - bus.i_trace_idx) & TRACE_MASK;
  assign mispc_read   = trace_mem[trace_rd_ptr];
`else
  logic unused_trace;
  assign unused_trace = ^{bus.i_trace_idx, TRACE_MASK};
  assign mispc_read   = last_mispc;
`endif

  logic [31:0] rd_next;

  always_comb begin
    rd_next = '0;
    case (bus.i_rd_sel)
      SEL_CYCLES:  rd_next = 32'(cnt[OVF_CYCLES]);
      SEL_RETIRED: rd_next = 32'(cnt[OVF_RETIRED]);
      SEL_CTRL:    rd_next = 32'(cnt[OVF_CTRL]);
      SEL_MISPRED: rd_next = 32'(cnt[OVF_MISPRED]);
      SEL_BUBBLES: rd_next = 32'(cnt[OVF_BUBBLES]);
      SEL_OVF:     rd_next = 32'(ovf);
      SEL_PC:      rd_next = last_pc;
      SEL_MISPC:   rd_next = mispc_read;
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) bus.o_rd_data <= '0;
    else         bus.o_rd_data <= rd_next;
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench: a full-width and a 4-bit-counter instance share one
// stimulus stream and are compared against a count-based reference model.
module tb_perf_counter_unit;

  localparam int TRACE_DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  perf_counter_unit_if bus ();
  perf_counter_unit_if bus4 ();

  assign bus4.i_insn_vld  = bus.i_insn_vld;
  assign bus4.i_ctrl      = bus.i_ctrl;
  assign bus4.i_mispred   = bus.i_mispred;
  assign bus4.i_pc        = bus.i_pc;
  assign bus4.i_cmd_valid = bus.i_cmd_valid;
  assign bus4.i_cmd       = bus.i_cmd;
  assign bus4.i_rd_sel    = bus.i_rd_sel;
  assign bus4.i_trace_idx = bus.i_trace_idx;

  perf_counter_unit #(.COUNT_W(32), .TRACE_DEPTH(TRACE_DEPTH)) dut (
    .i_clk (clk), .i_reset (rst), .bus (bus)
  );

  perf_counter_unit #(.COUNT_W(4), .TRACE_DEPTH(TRACE_DEPTH)) dut4 (
    .i_clk (clk), .i_reset (rst), .bus (bus4)
  );

  // Reference model: true (unsaturated) event totals since the last clear;
  // each width's view is derived from them.
  longint unsigned m_cnt [5];
  logic [31:0]     m_last_pc, m_last_mispc;
  logic [31:0]     m_trace [$];
  int              m_state;
  logic [31:0]     m_rd, m_rd4;

  function automatic longint unsigned max_of(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [31:0] model_read(int w, logic [2:0] sel, logic [2:0] idx);
    logic [31:0] r;
    int j;
    r = '0;
    if (sel <= 3'd4) begin
      r = 32'((m_cnt[sel] > max_of(w)) ? max_of(w) : m_cnt[sel]);
    end else if (sel == 3'd5) begin
      for (int i = 0; i < 5; i++) r[i] = (m_cnt[i] > max_of(w));
    end else if (sel == 3'd6) begin
      r = m_last_pc;
    end else begin
`ifdef PERF_MISPRED_TRACE_EN
      j = int'(idx) % TRACE_DEPTH;
      if (j < m_trace.size()) r = m_trace[m_trace.size() - 1 - j];
`else
      j = int'(idx);
      r = m_last_mispc + 32'(j * 0);
`endif
    end
    return r;
  endfunction

  function automatic logic model_ovf(int w);
    logic o;
    o = 1'b0;
    for (int i = 0; i < 5; i++) if (m_cnt[i] > max_of(w)) o = 1'b1;
    return o;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_last_pc    = '0;
    m_last_mispc = '0;
    m_trace.delete();
  endtask

  task automatic model_reset();
    model_clear();
    m_state = 0;
    m_rd    = '0;
    m_rd4   = '0;
  endtask

  // Advances the model by the clock edge about to happen, then waits for it.
  task automatic tick();
    m_rd  = model_read(32, bus.i_rd_sel, bus.i_trace_idx);
    m_rd4 = model_read(4, bus.i_rd_sel, bus.i_trace_idx);
    if (m_state == 1) begin
      m_cnt[0]++;
      if (bus.i_insn_vld) begin
        m_cnt[1]++;
        m_last_pc = bus.i_pc;
        if (bus.i_ctrl) m_cnt[2]++;
        if (bus.i_mispred) begin
          m_cnt[3]++;
          m_last_mispc = bus.i_pc;
          m_trace.push_back(bus.i_pc);
          if (m_trace.size() > TRACE_DEPTH) void'(m_trace.pop_front());
        end
      end else begin
        m_cnt[4]++;
      end
    end
    if (m_state == 3) begin
      model_clear();
      m_state = 0;
    end else if (bus.i_cmd_valid) begin
      case (bus.i_cmd)
        2'd1: m_state = 1;
        2'd2: if (m_state == 1) m_state = 2;
        2'd3: m_state = 3;
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_commit(logic vld, logic ctrl, logic mis, logic [31:0] pc);
    bus.i_insn_vld = vld;
    bus.i_ctrl     = ctrl;
    bus.i_mispred  = mis;
    bus.i_pc       = pc;
  endtask

  task automatic issue(logic [1:0] cmd);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = cmd;
    tick();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = 2'd0;
  endtask

  task automatic do_clear();
    set_commit(1'b0, 1'b0, 1'b0, '0);
    issue(2'd3);
    tick();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.o_state); end
    checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.o_cmd_ready); end
    checks++; if (bus.o_ovf !== 1'b0 || bus4.o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b/%b want 0", bus.o_ovf, bus4.o_ovf); end
    checks++; if (bus.o_rd_data !== 32'd0 || bus4.o_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h/%h want 0", bus.o_rd_data, bus4.o_rd_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [9:0] vld_pat  = 10'b1010101011;
    logic [9:0] ctrl_pat = 10'b0000101101;
    logic [9:0] mis_pat  = 10'b0000000110;
    logic [31:0] exp [5] = '{32'd10, 32'd6, 32'd3, 32'd1, 32'd4};
    // START-accept cycle carries a full event that must not count.
    set_commit(1'b1, 1'b1, 1'b1, 32'h50);
    issue(2'd1);
    checks++; if (bus.o_state !== 2'd1) begin errors++; $display("FAIL basic_run: got %0d want 1", bus.o_state); end
    for (int i = 0; i < 10; i++) begin
      set_commit(vld_pat[i], ctrl_pat[i], mis_pat[i], 32'h1000 + 32'(4 * i));
      bus.i_cmd_valid = (i == 9);
      bus.i_cmd       = 2'd2;
      tick();
    end
    bus.i_cmd_valid = 1'b0;
    set_commit(1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.o_state !== 2'd2) begin errors++; $display("FAIL basic_frozen: got %0d want 2", bus.o_state); end
    for (int s = 0; s < 5; s++) begin
      bus.i_rd_sel = 3'(s);
      tick();
      checks++; if (bus.o_rd_data !== exp[s]) begin errors++; $display("FAIL basic_sel%0d: got %0d want %0d", s, bus.o_rd_data, exp[s]); end
      checks++; if (bus4.o_rd_data !== exp[s]) begin errors++; $display("FAIL basic4_sel%0d: got %0d want %0d", s, bus4.o_rd_data, exp[s]); end
    end
  endtask

  task automatic test_clear();
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = 2'd3;
    tick();
    checks++; if (bus.o_cmd_ready !== 1'b0 || bus.o_state !== 2'd3) begin errors++; $display("FAIL clear_enter: got ready %b state %0d want 0/3", bus.o_cmd_ready, bus.o_state); end
    tick();
    checks++; if (bus.o_cmd_ready !== 1'b1 || bus.o_state !== 2'd0) begin errors++; $display("FAIL clear_exit: got ready %b state %0d want 1/0", bus.o_cmd_ready, bus.o_state); end
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = 2'd0;
    for (int s = 0; s < 8; s++) begin
      bus.i_rd_sel = 3'(s);
      tick();
      checks++; if (bus.o_rd_data !== 32'd0 || bus4.o_rd_data !== 32'd0) begin errors++; $display("FAIL clear_sel%0d: got %h/%h want 0", s, bus.o_rd_data, bus4.o_rd_data); end
    end
  endtask

  task automatic test_saturation();
    issue(2'd1);
    for (int i = 0; i < 20; i++) begin
      set_commit((i % 2) == 0, 1'b0, 1'b0, 32'h2000);
      bus.i_cmd_valid = (i == 19);
      bus.i_cmd       = 2'd2;
      tick();
    end
    bus.i_cmd_valid = 1'b0;
    set_commit(1'b0, 1'b0, 1'b0, '0);
    bus.i_rd_sel = 3'd0;
    tick();
    checks++; if (bus4.o_rd_data !== 32'd15) begin errors++; $display("FAIL sat4_cycles: got %0d want 15", bus4.o_rd_data); end
    checks++; if (bus.o_rd_data !== 32'd20) begin errors++; $display("FAIL sat32_cycles: got %0d want 20", bus.o_rd_data); end
    bus.i_rd_sel = 3'd5;
    tick();
    checks++; if (bus4.o_rd_data !== 32'h1) begin errors++; $display("FAIL sat4_ovfword: got %h want 1", bus4.o_rd_data); end
    checks++; if (bus.o_rd_data !== 32'h0) begin errors++; $display("FAIL sat32_ovfword: got %h want 0", bus.o_rd_data); end
    checks++; if (bus4.o_ovf !== 1'b1 || bus.o_ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf: got %b/%b want 1/0", bus4.o_ovf, bus.o_ovf); end
    do_clear();
    checks++; if (bus4.o_ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear: got %b want 0", bus4.o_ovf); end
    for (int s = 0; s < 8; s++) begin
      bus.i_rd_sel = 3'(s);
      tick();
      checks++; if (bus.o_rd_data !== 32'd0 || bus4.o_rd_data !== 32'd0) begin errors++; $display("FAIL sat_clear_sel%0d: got %h/%h want 0", s, bus.o_rd_data, bus4.o_rd_data); end
    end
  endtask

  task automatic test_last_pc();
    logic [31:0] pcs [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] exp [5] = '{32'd4, 32'd3, 32'd0, 32'd1, 32'd1};
    bus.i_trace_idx = 3'd0;
    issue(2'd1);
    for (int i = 0; i < 3; i++) begin
      set_commit(1'b1, 1'b0, i == 1, pcs[i]);
      tick();
    end
    set_commit(1'b0, 1'b0, 1'b0, '0);
    issue(2'd2);
    // Commits while frozen must leave every readout untouched.
    for (int i = 0; i < 4; i++) begin
      set_commit(1'b1, 1'b1, 1'b1, 32'h200 + 32'(4 * i));
      tick();
    end
    set_commit(1'b0, 1'b0, 1'b0, '0);
    bus.i_rd_sel = 3'd6;
    tick();
    checks++; if (bus.o_rd_data !== 32'h108) begin errors++; $display("FAIL last_pc: got %h want 108", bus.o_rd_data); end
    bus.i_rd_sel = 3'd7;
    tick();
    checks++; if (bus.o_rd_data !== 32'h104) begin errors++; $display("FAIL last_mispc: got %h want 104", bus.o_rd_data); end
    for (int s = 0; s < 5; s++) begin
      bus.i_rd_sel = 3'(s);
      tick();
      checks++; if (bus.o_rd_data !== exp[s]) begin errors++; $display("FAIL frozen_sel%0d: got %0d want %0d", s, bus.o_rd_data, exp[s]); end
    end
  endtask

`ifdef PERF_MISPRED_TRACE_EN
  task automatic test_trace();
    logic [2:0]  idxs [3] = '{3'd0, 3'd1, 3'd7};
    logic [31:0] exp  [3] = '{32'h90, 32'h80, 32'h20};
    do_clear();
    issue(2'd1);
    for (int k = 1; k <= 9; k++) begin
      set_commit(1'b1, 1'b1, 1'b1, 32'(16 * k));
      tick();
    end
    set_commit(1'b0, 1'b0, 1'b0, '0);
    issue(2'd2);
    bus.i_rd_sel = 3'd7;
    for (int i = 0; i < 3; i++) begin
      bus.i_trace_idx = idxs[i];
      tick();
      checks++; if (bus.o_rd_data !== exp[i]) begin errors++; $display("FAIL trace_idx%0d: got %h want %h", idxs[i], bus.o_rd_data, exp[i]); end
    end
  endtask
`endif

  task automatic test_random();
    int r;
    do_clear();
    issue(2'd1);
    for (int n = 0; n < 600; n++) begin
      set_commit($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom & 32'hffff_fffc);
      r = $urandom_range(0, 15);
      bus.i_cmd_valid = ($urandom_range(0, 3) == 0);
      bus.i_cmd       = (r == 0) ? 2'd3 : (r < 7) ? 2'd1 : (r < 12) ? 2'd2 : 2'd0;
      bus.i_rd_sel    = 3'($urandom);
      bus.i_trace_idx = 3'($urandom);
      tick();
      checks++; if (bus.o_rd_data !== m_rd) begin errors++; $display("FAIL rand_rd n=%0d: got %h want %h", n, bus.o_rd_data, m_rd); end
      checks++; if (bus4.o_rd_data !== m_rd4) begin errors++; $display("FAIL rand_rd4 n=%0d: got %h want %h", n, bus4.o_rd_data, m_rd4); end
      checks++; if (bus.o_state !== 2'(m_state)) begin errors++; $display("FAIL rand_state n=%0d: got %0d want %0d", n, bus.o_state, m_state); end
      checks++; if (bus.o_cmd_ready !== (m_state != 3)) begin errors++; $display("FAIL rand_ready n=%0d: got %b", n, bus.o_cmd_ready); end
      checks++; if (bus4.o_ovf !== model_ovf(4) || bus.o_ovf !== model_ovf(32)) begin errors++; $display("FAIL rand_ovf n=%0d: got %b/%b want %b/%b", n, bus4.o_ovf, bus.o_ovf, model_ovf(4), model_ovf(32)); end
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_trace_idx = 3'd0;
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    issue(2'd1);
    bus.i_rd_sel = 3'd0;
    for (int i = 0; i < 20; i++) begin
      set_commit(1'b1, 1'b0, 1'b0, 32'h300);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_rd_data !== 32'd0 || bus4.o_rd_data !== 32'd0) begin errors++; $display("FAIL midrst_rd: got %h/%h want 0", bus.o_rd_data, bus4.o_rd_data); end
    checks++; if (bus.o_state !== 2'd0 || bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_state: got %0d ready %b want 0/1", bus.o_state, bus.o_cmd_ready); end
    checks++; if (bus4.o_ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", bus4.o_ovf); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    issue(2'd1);
    for (int i = 0; i < 3; i++) begin
      bus.i_cmd_valid = (i == 2);
      bus.i_cmd       = 2'd2;
      tick();
    end
    bus.i_cmd_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      bus.i_rd_sel = 3'(s);
      tick();
      checks++; if (bus.o_rd_data !== 32'd3) begin errors++; $display("FAIL midrst_restart_sel%0d: got %0d want 3", s, bus.o_rd_data); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_commit(1'b0, 1'b0, 1'b0, '0);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = 2'd0;
    bus.i_rd_sel    = 3'd0;
    bus.i_trace_idx = 3'd0;
    model_reset();
    test_reset();
    test_basic();
    test_clear();
    test_saturation();
    test_last_pc();
`ifdef PERF_MISPRED_TRACE_EN
    test_trace();
`endif
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Sits directly downstream of the pipelined core's WB-stage debug/commit outputs (PC, instruction-valid, control, mispredict).
- Counts cycles, retired instructions, control-flow instructions, mispredictions and bubble cycles under a start/stop/clear command FSM.
- Exposes one registered 32-bit readout port for software/testbench inspection of branch-predictor effectiveness.

Parameters:
- COUNT_W, 32, width of each event counter (1..32); counters saturate at 2^COUNT_W-1.
- TRACE_DEPTH, 8, depth of the mispredict PC trace buffer; power of two, max 8; used only with the optional feature.

Ports:
- i_clk  input  1  core clock
- i_reset  input  1  asynchronous, active-high reset
- i_insn_vld  input  1  committed instruction valid in WB this cycle
- i_ctrl  input  1  committed instruction is branch/jump
- i_mispred  input  1  committed instruction was mispredicted
- i_pc  input  32  PC of the committed instruction
- i_cmd_valid  input  1  command request
- i_cmd  input  2  00 NOP, 01 START, 10 STOP, 11 CLEAR
- o_cmd_ready  output  1  command can be accepted this cycle
- i_rd_sel  input  3  readout select
- i_trace_idx  input  3  trace entry age (0 = newest); ignored without the optional feature
- o_rd_data  output  32  registered readout
- o_state  output  2  current FSM state encoding
- o_ovf  output  1  OR of all sticky overflow flags

Behaviour:
- Reset: async on i_reset high. All counters, overflow flags, last-PC registers and o_rd_data = 0; state IDLE; o_state = 0; o_cmd_ready = 1; o_ovf = 0.
- States: IDLE = 0, RUN = 1, FROZEN = 2, CLEAR = 3.
- A command is accepted when i_cmd_valid & o_cmd_ready. o_cmd_ready = 0 only in CLEAR.
- START: IDLE or FROZEN -> RUN. Ignored in RUN.
- STOP: RUN -> FROZEN. Ignored in IDLE or FROZEN.
- CLEAR: from any state -> CLEAR. CLEAR lasts exactly 1 cycle, zeroes every counter, flag and PC register, then goes to IDLE.
- NOP: no effect.
- Counting happens only in cycles where state == RUN:
  - cycles += 1 every RUN cycle.
  - retired += i_insn_vld.
  - ctrl += i_insn_vld & i_ctrl.
  - mispred += i_insn_vld & i_mispred.
  - bubbles += ~i_insn_vld.
  - i_ctrl and i_mispred are ignored when i_insn_vld = 0.
- Command-accept cycle timing:
  - START: state is still IDLE/FROZEN, so no count that cycle; counting begins the next cycle.
  - STOP: state is still RUN, so events in that cycle are counted.
  - Events during CLEAR are dropped.
- Saturation: a counter at its maximum holds its value and sets its sticky overflow flag. The flag clears only on CLEAR or reset.
- Last-PC registers, updated only in RUN:
  - last_pc <= i_pc on every i_insn_vld.
  - last_mispc <= i_pc on i_insn_vld & i_mispred.
- Readout: 1-cycle latency. o_rd_data <= f(i_rd_sel) on every clock, valid in any state.
  - 0: cycles
  - 1: retired
  - 2: ctrl
  - 3: mispred
  - 4: bubbles
  - 5: {27'b0, ovf[4:0]} in the order cycles, retired, ctrl, mispred, bubbles (bit 0 = cycles)
  - 6: last_pc
  - 7: last_mispc
  - Counters are zero-extended to 32 bits.
- In FROZEN, all values hold stable, so multi-register reads are consistent.
- Reset mid-RUN: immediate return to the reset state; no partial counts survive.

Optional Feature:
- Macro: PERF_MISPRED_TRACE_EN.
- With the macro: a TRACE_DEPTH-entry circular buffer records i_pc on each RUN-cycle i_insn_vld & i_mispred.
  - The write pointer wraps; the oldest entry is overwritten.
  - rd_sel 7 returns the entry i_trace_idx positions older than the newest, with the index taken modulo TRACE_DEPTH.
  - Entries never written read 0. CLEAR and reset empty the buffer and zero the pointer.
- Without the macro: no buffer is built, i_trace_idx is ignored, and rd_sel 7 returns last_mispc.

Decomposition:
- Package perf_pkg holds:
  - state enum: IDLE, RUN, FROZEN, CLEAR
  - command enum: NOP, START, STOP, CLEAR
  - readout select constants SEL_CYCLES .. SEL_MISPC
  - overflow bit index constants
- One sub-module, perf_sat_counter, parameterised on COUNT_W:
  - inputs: clk, async reset, clear, inc
  - outputs: count, sticky ovf
  - instantiated 5 times.

Test Plan:
- Reset, then START, then 10 RUN cycles with i_insn_vld = 1 on 6 of them (3 with i_ctrl, 1 with i_mispred), then STOP -> reads give cycles = 10, retired = 6, ctrl = 3, mispred = 1, bubbles = 4, each appearing one cycle after i_rd_sel is applied.
- STOP accepted on a cycle with i_insn_vld = 1 -> that instruction is counted. START-accept cycle events are not counted. Hold i_cmd_valid for CLEAR -> o_cmd_ready = 0 for exactly 1 cycle, then state = IDLE.
- COUNT_W = 4 with 20 RUN cycles -> cycles = 15, rd_sel 5 = 0x1, o_ovf = 1. CLEAR -> all reads 0 and o_ovf = 0.
- Commit PCs 0x100, 0x104 (mispred), 0x108 in RUN -> rd_sel 6 = 0x108, rd_sel 7 = 0x104. FROZEN followed by i_insn_vld pulses -> values unchanged.
- With PERF_MISPRED_TRACE_EN and TRACE_DEPTH = 8: mispredicts at PCs 0x10, 0x20, ..., 0x90 (9 events) -> idx 0 = 0x90, idx 7 = 0x20 (0x10 overwritten).
- Assert i_reset mid-RUN with nonzero counts -> all outputs 0 asynchronously, state IDLE, and a new START counts from 0.
